// File: rtl/fm_modulator.sv
// fm_modulator: turns a ufix13_En12 message stream into constant-envelope FM
// baseband I/Q in sfix39_En36. The message frequency-modulates a 32-bit NCO
// phase, and a quarter-wave sine LUT folded by quadrant produces cos/sin.
// Pipeline: fcw -> accumulator -> LUT read -> sign fold/scale (4 enabled cycles).
// Optional build macro PHASE_DITHER_EN: adds LFSR dither below the LUT index.
module fm_modulator #(
  parameter logic [31:0] CARRIER_FCW = 32'd0,
  parameter int unsigned K_DEV       = 256,
  parameter int          LUT_ABITS   = 10,
  parameter int          LUT_DW      = 18
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_enable,
  input  logic               phase_clear,
  input  logic [12:0]        in_msg,
  output logic signed [38:0] out_I,
  output logic signed [38:0] out_Q,
  output logic               out_valid
);

  localparam int N     = 1 << LUT_ABITS;
  localparam int AMP   = (1 << (LUT_DW - 1)) - 1;
  localparam int SHIFT = 37 - LUT_DW;

  localparam logic signed [32:0] K_DEV_S = 33'(K_DEV);
  localparam logic signed [32:0] CARR_S  = {1'b0, CARRIER_FCW};

  // Elaboration-time sine via Taylor series; argument stays within (0, pi/2).
  function automatic real sin_r(input real x);
    real term;
    real sum;
    term = x;
    sum  = x;
    for (int k = 1; k < 12; k++) begin
      term = -term * x * x / real'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  // Half-sample-offset quarter-wave entry, rounded to nearest.
  function automatic int lut_val(input int i);
    real th;
    th = 2.0 * 3.14159265358979323846 * (real'(i) + 0.5) / (4.0 * real'(N));
    return int'(real'(AMP) * sin_r(th));
  endfunction

  // Positive LUT magnitude, optionally negated, sign-extended and scaled to En36.
  function automatic logic signed [38:0] scale_out(input logic [LUT_DW-1:0] mag,
                                                   input logic neg);
    logic signed [38:0] v;
    v = 39'($signed({1'b0, mag}));
    if (neg) v = -v;
    return v <<< SHIFT;
  endfunction

  logic [LUT_DW-1:0] lut [N];
  for (genvar g = 0; g < N; g++) begin : g_lut
    assign lut[g] = LUT_DW'(lut_val(g));
  end

  logic signed [13:0] dmsg;
  logic signed [32:0] dev;
  logic [31:0]        fcw_p1;
  logic [31:0]        acc_p2;
  logic [31:0]        phase;
  logic [LUT_ABITS-1:0] idx;
  logic [1:0]         q_p3;
  logic [LUT_DW-1:0]  s_p3;
  logic [LUT_DW-1:0]  c_p3;
  logic               vld_p1, vld_p2, vld_p3, vld_p4;

  assign dmsg = $signed({1'b0, in_msg}) - 14'sd4096;
  assign dev  = 33'(dmsg) * K_DEV_S;

  // Stage 1: message offset times deviation gain plus carrier, wrapped to 32 bits.
  always_ff @(posedge clk) begin
    if (!reset)          fcw_p1 <= '0;
    else if (clk_enable) fcw_p1 <= 32'(CARR_S + dev);
  end

  // Stage 2: phase accumulator; clear wins over the add even when not enabled.
  always_ff @(posedge clk) begin
    if (!reset)           acc_p2 <= '0;
    else if (phase_clear) acc_p2 <= '0;
    else if (clk_enable)  acc_p2 <= acc_p2 + fcw_p1;
  end

`ifdef PHASE_DITHER_EN
  localparam int DITH_W = (30 - LUT_ABITS > 16) ? 16 : 30 - LUT_ABITS;
  logic [15:0] lfsr;

  // Galois LFSR x^16+x^14+x^13+x^11+1 stepping once per sample.
  always_ff @(posedge clk) begin
    if (!reset)          lfsr <= 16'hACE1;
    else if (clk_enable) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  assign phase = acc_p2 + 32'(lfsr[DITH_W-1:0]);
`else
  assign phase = acc_p2;
`endif

  assign idx = LUT_ABITS'(phase >> (30 - LUT_ABITS));

  // Stage 3: quadrant plus both LUT reads; N-1-idx is ~idx since N is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_p3 <= '0;
      s_p3 <= '0;
      c_p3 <= '0;
    end else if (clk_enable) begin
      q_p3 <= phase[31:30];
      s_p3 <= lut[idx];
      c_p3 <= lut[~idx];
    end
  end

  // Stage 4: fold quarter-wave magnitudes into signed cos/sin by quadrant.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_I <= '0;
      out_Q <= '0;
    end else if (clk_enable) begin
      case (q_p3)
        2'd0: begin out_I <= scale_out(c_p3, 1'b0); out_Q <= scale_out(s_p3, 1'b0); end
        2'd1: begin out_I <= scale_out(s_p3, 1'b1); out_Q <= scale_out(c_p3, 1'b0); end
        2'd2: begin out_I <= scale_out(c_p3, 1'b1); out_Q <= scale_out(s_p3, 1'b1); end
        default: begin out_I <= scale_out(s_p3, 1'b0); out_Q <= scale_out(c_p3, 1'b1); end
      endcase
    end
  end

  // Valid shift register fed with 1; only reset empties it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
      vld_p4 <= 1'b0;
    end else if (clk_enable) begin
      vld_p1 <= 1'b1;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      vld_p4 <= vld_p3;
    end
  end

  assign out_valid = vld_p4;

endmodule

// File: tb/tb_fm_modulator.sv
// tb_fm_modulator: directed checks of fm_modulator. Two instances share the
// inputs: default carrier (0) and a quarter-cycle carrier (2^30) whose output
// rotates through all four quadrants each sample.
module tb_fm_modulator;

  logic               clk = 1'b0;
  logic               reset;
  logic               clk_enable;
  logic               phase_clear;
  logic [12:0]        in_msg;
  logic signed [38:0] oi, oq, ci, cq;
  logic               ov, cv;

  int checks = 0;
  int passed = 0;

  localparam logic signed [38:0] P_HI = 39'sd131071 <<< 19;
  localparam logic signed [38:0] P_LO = 39'sd101 <<< 19;
  localparam logic signed [38:0] N_HI = -P_HI;
  localparam logic signed [38:0] N_LO = -P_LO;

  fm_modulator dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .phase_clear(phase_clear),
    .in_msg(in_msg), .out_I(oi), .out_Q(oq), .out_valid(ov)
  );

  fm_modulator #(.CARRIER_FCW(32'h4000_0000)) dut_c (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .phase_clear(phase_clear),
    .in_msg(in_msg), .out_I(ci), .out_Q(cq), .out_valid(cv)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [38:0] obs, input logic [38:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  initial begin
    logic signed [38:0] rot_i [4];
    logic signed [38:0] rot_q [4];
    rot_i = '{N_HI, P_LO, P_HI, N_LO};
    rot_q = '{N_LO, N_HI, P_LO, P_HI};

    reset = 1'b0; clk_enable = 1'b0; phase_clear = 1'b0; in_msg = 13'd4096;
    tick(2);
    check("rst_I", oi, 39'd0);
    check("rst_Q", oq, 39'd0);
    check("rst_valid", 39'(ov), 39'd0);
    check("rst_acc", 39'(dut.acc_p2), 39'd0);
    check("rst_c_I", ci, 39'd0);
    check("rst_c_valid", 39'(cv), 39'd0);

    // Zero carrier, midscale message: constant phase 0.
    reset = 1'b1; clk_enable = 1'b1;
    tick(3);
    check("valid_after3", 39'(ov), 39'd0);
    tick(1);
    check("valid_after4", 39'(ov), 39'd1);
    check("dc_I", oi, P_HI);
    check("dc_Q", oq, P_LO);
    check("c_valid", 39'(cv), 39'd1);
    check("c_ph1_I", ci, N_LO);
    check("c_ph1_Q", cq, P_HI);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check("c_rot_I", ci, rot_i[k]);
      check("c_rot_Q", cq, rot_q[k]);
      check("dc_hold_I", oi, P_HI);
    end

    // Deviation up then down returns the accumulator to zero.
    in_msg = 13'd4097;
    tick(8);
    check("dev_up_acc", 39'(dut.acc_p2), 39'd1792);
    in_msg = 13'd4095;
    tick(1);
    check("dev_peak_acc", 39'(dut.acc_p2), 39'd2048);
    tick(7);
    check("dev_down_acc", 39'(dut.acc_p2), 39'd256);
    in_msg = 13'd4096;
    tick(1);
    check("dev_zero_acc", 39'(dut.acc_p2), 39'd0);
    tick(1);
    check("dev_zero_hold", 39'(dut.acc_p2), 39'd0);
    tick(2);
    check("dev_out_I", oi, P_HI);
    check("dev_out_Q", oq, P_LO);

    // Enable gating and phase clear while disabled.
    in_msg = 13'd4097;
    tick(3);
    check("gate_acc_pre", 39'(dut.acc_p2), 39'd512);
    clk_enable = 1'b0; in_msg = 13'd5000;
    tick(1);
    check("gate_acc_hold", 39'(dut.acc_p2), 39'd512);
    check("gate_fcw_hold", 39'(dut.fcw_p1), 39'd256);
    check("gate_valid_hold", 39'(ov), 39'd1);
    phase_clear = 1'b1;
    tick(1);
    check("clear_acc", 39'(dut.acc_p2), 39'd0);
    check("clear_c_acc", 39'(dut_c.acc_p2), 39'd0);
    check("clear_fcw_hold", 39'(dut.fcw_p1), 39'd256);
    phase_clear = 1'b0; clk_enable = 1'b1; in_msg = 13'd4097;
    tick(1);
    check("after_clear_acc", 39'(dut.acc_p2), 39'd256);
    check("after_clear_c_acc", 39'(dut_c.acc_p2), 39'h0_4000_0100);
    tick(1);
    check("clr_ph0_I", ci, P_HI);
    check("clr_ph0_Q", cq, P_LO);
    tick(1);
    check("clr_ph1_I", ci, N_LO);
    check("clr_ph1_Q", cq, P_HI);
    tick(1);
    check("clr_ph2_I", ci, N_HI);
    check("clr_ph2_Q", cq, N_LO);

    // One-cycle reset mid-stream.
    reset = 1'b0;
    tick(1);
    check("mid_rst_I", oi, 39'd0);
    check("mid_rst_Q", oq, 39'd0);
    check("mid_rst_valid", 39'(ov), 39'd0);
    check("mid_rst_acc", 39'(dut.acc_p2), 39'd0);
    check("mid_rst_c_valid", 39'(cv), 39'd0);
    reset = 1'b1; in_msg = 13'd4096;
    tick(3);
    check("mid_valid_after3", 39'(ov), 39'd0);
    tick(1);
    check("mid_valid_after4", 39'(ov), 39'd1);
    check("mid_dc_I", oi, P_HI);
    check("mid_dc_Q", oq, P_LO);
    check("mid_c_I", ci, N_LO);
    check("mid_c_Q", cq, P_HI);

    // Accumulator wrap 0xFFFFFF00 + 0x200 -> 0x100.
    in_msg = 13'd4095;
    tick(1);
    in_msg = 13'd4098;
    tick(1);
    check("wrap_acc_pre", 39'(dut.acc_p2), 39'h0_FFFF_FF00);
    in_msg = 13'd4096;
    tick(1);
    check("wrap_acc_post", 39'(dut.acc_p2), 39'h0_0000_0100);
    tick(1);
    check("wrap_q3_I", oi, P_HI);
    check("wrap_q3_Q", oq, N_LO);
    tick(1);
    check("wrap_q0_I", oi, P_HI);
    check("wrap_q0_Q", oq, P_LO);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
